// File: rtl/parking_pkg.sv
// Shared types and constants for the 4-slot parking lot controller.
package parking_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;
   localparam int CAP_W     = 3;

   localparam logic [NUM_SLOTS-1:0] FULL_MAP = 4'b0000;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_GATE = 2'd1,
      EXIT_GATE  = 2'd2
   } park_state_t;

   // Number of free slots in a free map (bit set = slot free).
   function automatic logic [CAP_W-1:0] free_count(input logic [NUM_SLOTS-1:0] map);
      logic [CAP_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         n = n + CAP_W'(map[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/parking_slot_controller_slot_allocator.sv
// Combinational slot picker: first free slot scanning upward from i_start, wrapping.
// The caller ties i_start to 0 unless PARKING_RR_ALLOC_EN is defined.
module slot_allocator
   import parking_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] i_free_map,
   input  logic [SLOT_W-1:0]    i_start,
   output logic [SLOT_W-1:0]    o_slot,
   output logic                 o_found
);

   always_comb begin
      logic [SLOT_W-1:0] idx;
      o_slot  = '0;
      o_found = 1'b0;
      idx     = '0;
      // Scan from the farthest offset back to the start so the nearest free slot wins.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         idx = i_start + SLOT_W'(i);
         if (i_free_map[idx]) begin
            o_slot  = idx;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/parking_slot_controller.sv
// Occupancy and gate controller for a 4-slot lot: arbitrates entry/exit, tracks the free map
// and drives gate strobes. Define PARKING_RR_ALLOC_EN for round-robin slot allocation.
module parking_slot_controller
   import parking_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 entry_req,
   input  logic                 exit_req,
   input  logic [SLOT_W-1:0]    exit_slot,
   output logic                 entry_ack,
   output logic                 entry_nak,
   output logic                 exit_ack,
   output logic                 exit_nak,
   output logic                 gate_in,
   output logic                 gate_out,
   output logic [SLOT_W-1:0]    location,
   output logic [CAP_W-1:0]     capacity,
   output logic [NUM_SLOTS-1:0] E
);

   localparam int               CNT_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

   park_state_t          r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [NUM_SLOTS-1:0] r_free, w_free_nxt;
   logic [CAP_W-1:0]     r_cap;
   logic [SLOT_W-1:0]    r_loc, w_loc_nxt;
   logic                 r_entry_ack, w_entry_ack_nxt;
   logic                 r_entry_nak, w_entry_nak_nxt;
   logic                 r_exit_ack, w_exit_ack_nxt;
   logic                 r_exit_nak, w_exit_nak_nxt;

   logic [SLOT_W-1:0]    w_alloc_start;
   logic [SLOT_W-1:0]    w_alloc_slot;
   logic                 w_alloc_found;

`ifdef PARKING_RR_ALLOC_EN
   // Holds the slot after the last one allocated, i.e. where the next scan begins.
   logic [SLOT_W-1:0]    r_rr_ptr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rr_ptr <= '0;
      end else if (w_entry_ack_nxt) begin
         r_rr_ptr <= w_alloc_slot + SLOT_W'(1);
      end
   end

   assign w_alloc_start = r_rr_ptr;
`else
   assign w_alloc_start = '0;
`endif

   slot_allocator u_alloc (
      .i_free_map (r_free),
      .i_start    (w_alloc_start),
      .o_slot     (w_alloc_slot),
      .o_found    (w_alloc_found)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_free      <= '1;
         r_cap       <= CAP_W'(NUM_SLOTS);
         r_loc       <= '0;
         r_entry_ack <= 1'b0;
         r_entry_nak <= 1'b0;
         r_exit_ack  <= 1'b0;
         r_exit_nak  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_free      <= w_free_nxt;
         r_cap       <= free_count(w_free_nxt);
         r_loc       <= w_loc_nxt;
         r_entry_ack <= w_entry_ack_nxt;
         r_entry_nak <= w_entry_nak_nxt;
         r_exit_ack  <= w_exit_ack_nxt;
         r_exit_nak  <= w_exit_nak_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_free_nxt      = r_free;
      w_loc_nxt       = r_loc;
      w_entry_ack_nxt = 1'b0;
      w_entry_nak_nxt = 1'b0;
      w_exit_ack_nxt  = 1'b0;
      w_exit_nak_nxt  = 1'b0;

      unique case (r_state)
         IDLE: begin
            // Exit wins; a refused exit still blocks the entry for this cycle.
            if (exit_req) begin
               if (!r_free[exit_slot]) begin
                  w_free_nxt[exit_slot] = 1'b1;
                  w_exit_ack_nxt        = 1'b1;
                  w_cnt_nxt             = CNT_LOAD;
                  w_state_nxt           = EXIT_GATE;
               end else begin
                  w_exit_nak_nxt = 1'b1;
               end
            end else if (entry_req) begin
               if ((r_free != FULL_MAP) && w_alloc_found) begin
                  w_free_nxt[w_alloc_slot] = 1'b0;
                  w_loc_nxt                = w_alloc_slot;
                  w_entry_ack_nxt          = 1'b1;
                  w_cnt_nxt                = CNT_LOAD;
                  w_state_nxt              = ENTRY_GATE;
               end else begin
                  w_entry_nak_nxt = 1'b1;
               end
            end
         end
         ENTRY_GATE, EXIT_GATE: begin
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign gate_in   = (r_state == ENTRY_GATE);
   assign gate_out  = (r_state == EXIT_GATE);
   assign entry_ack = r_entry_ack;
   assign entry_nak = r_entry_nak;
   assign exit_ack  = r_exit_ack;
   assign exit_nak  = r_exit_nak;
   assign location  = r_loc;
   assign capacity  = r_cap;
   assign E         = r_free;

endmodule
